// File: rtl/score_bcd_encoder.sv
// score_bcd_encoder: keeps the binary game score and converts it to four
// packed BCD digits with a sequential double-dabble engine. It also tracks
// a running high score for the display driver.
module score_bcd_encoder #(
  parameter int SCORE_W   = 14,
  parameter int SCORE_MAX = 9999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               score_inc,
  input  logic               score_clr,
  input  logic               lost,
  output logic [SCORE_W-1:0] score_bin,
  output logic [15:0]        score_bcd,
  output logic [15:0]        high_bcd,
  output logic               bcd_valid,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int                 CNT_W    = $clog2(SCORE_W + 1);
  localparam logic [SCORE_W-1:0] MAX_VAL  = SCORE_W'(SCORE_MAX);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(SCORE_W - 1);

  state_t                 state;
  state_t                 state_next;
  logic                   dirty;
  logic                   inc_ok;
  logic [SCORE_W-1:0]     shift_reg;
  logic [15:0]            scratch;
  logic [15:0]            dabbled;
  logic [15+SCORE_W:0]    shifted;
  logic [CNT_W-1:0]       bit_cnt;

  // An increment only counts while the game is live and below saturation
  assign inc_ok = score_inc && !lost && (score_bin < MAX_VAL);

  // Score register and dirty flag. A score event in the LOAD cycle must keep
  // dirty set, because LOAD has captured the value from before that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_bin <= '0;
      dirty     <= 1'b0;
    end else begin
      if (score_clr) begin
        score_bin <= '0;
        dirty     <= 1'b1;
      end else if (inc_ok) begin
        score_bin <= score_bin + SCORE_W'(1);
        dirty     <= 1'b1;
      end else if (state == LOAD) begin
        dirty     <= 1'b0;
      end
    end
  end

  // Conversion FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and busy flag
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (dirty) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to each digit >= 5, then shift left by one
  always_comb begin
    dabbled = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        dabbled[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    shifted = {dabbled, shift_reg} << 1;
  end

  // Conversion datapath and display outputs; score_bcd only changes in DONE,
  // so the display never sees a partially converted value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      score_bcd <= '0;
      high_bcd  <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= (state == DONE);
      case (state)
        LOAD: begin
          shift_reg <= score_bin;
          scratch   <= '0;
          bit_cnt   <= '0;
        end
        SHIFT: begin
          scratch   <= shifted[15+SCORE_W:SCORE_W];
          shift_reg <= shifted[SCORE_W-1:0];
          bit_cnt   <= bit_cnt + CNT_W'(1);
        end
        DONE: begin
          score_bcd <= scratch;
          if (scratch > high_bcd) begin
            high_bcd <= scratch;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_encoder.sv
// tb_score_bcd_encoder: directed vectors and hand-written sequences for the
// score BCD encoder, checked against hand-computed expected values.
module tb_score_bcd_encoder;

  localparam int SCORE_W = 14;

  typedef struct {
    logic               clr;
    int                 n_inc;
    logic               lost_lvl;
    logic [SCORE_W-1:0] exp_bin;
    logic [15:0]        exp_bcd;
    logic [15:0]        exp_high;
    logic               chk_pulse;
    int                 exp_pulse;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic               score_inc;
  logic               score_clr;
  logic               lost;
  logic [SCORE_W-1:0] score_bin;
  logic [15:0]        score_bcd;
  logic [15:0]        high_bcd;
  logic               bcd_valid;
  logic               busy;

  int          checks;
  int          errors;
  int          pulse_cnt;
  logic [15:0] pulse_q[$];
  vec_t        vecs[8];

  score_bcd_encoder #(.SCORE_W(SCORE_W), .SCORE_MAX(9999)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .score_inc (score_inc),
    .score_clr (score_clr),
    .lost      (lost),
    .score_bin (score_bin),
    .score_bcd (score_bcd),
    .high_bcd  (high_bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every update strobe and the digits it presented
  always @(negedge clk) begin
    if (bcd_valid) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_q.push_back(score_bcd);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drive inputs for the next rising edge
  task automatic applyStimulus(input logic inc, input logic clr);
    @(negedge clk);
    score_inc = inc;
    score_clr = clr;
  endtask

  // Wait until the FSM has stayed idle for several cycles (bounded)
  task automatic settle(input string name);
    int idle_run;
    int cyc;
    idle_run = 0;
    cyc      = 0;
    while (idle_run < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (busy) idle_run = 0;
      else      idle_run++;
    end
    if (idle_run < 3) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_settle actual=busy required=idle", name);
    end
  endtask

  initial begin
    int base_cnt;
    int base_q;
    int cycles;

    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    rst_n     = 1'b0;
    score_inc = 1'b0;
    score_clr = 1'b0;
    lost      = 1'b0;

    vecs[0] = '{1'b0,   35, 1'b0, 14'd37,   16'h0037, 16'h0037, 1'b0, 0};
    vecs[1] = '{1'b0,    5, 1'b1, 14'd37,   16'h0037, 16'h0037, 1'b1, 0};
    vecs[2] = '{1'b1,    1, 1'b0, 14'd0,    16'h0000, 16'h0037, 1'b1, 1};
    vecs[3] = '{1'b0,    5, 1'b0, 14'd5,    16'h0005, 16'h0037, 1'b1, 2};
    vecs[4] = '{1'b0,   93, 1'b0, 14'd98,   16'h0098, 16'h0098, 1'b0, 0};
    vecs[5] = '{1'b1,    0, 1'b0, 14'd0,    16'h0000, 16'h0098, 1'b1, 1};
    vecs[6] = '{1'b1,    0, 1'b0, 14'd0,    16'h0000, 16'h0098, 1'b1, 1};
    vecs[7] = '{1'b0, 1234, 1'b0, 14'd1234, 16'h1234, 16'h1234, 1'b0, 0};

    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i[0], i[1]);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("rst_bin",   32'(score_bin), 32'd0);
    checkOutput("rst_bcd",   32'(score_bcd), 32'd0);
    checkOutput("rst_high",  32'(high_bcd),  32'd0);
    checkOutput("rst_valid", 32'(bcd_valid), 32'd0);
    checkOutput("rst_busy",  32'(busy),      32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("idle_pulses", 32'(pulse_cnt), 32'd0);
    checkOutput("idle_busy",   32'(busy),      32'd0);

    // Single increment latency: strobe appears after edge E17
    @(negedge clk);
    score_inc = 1'b1;
    @(posedge clk);
    #1;
    score_inc = 1'b0;
    checkOutput("lat_bin_e0",  32'(score_bin), 32'd1);
    checkOutput("lat_busy_e0", 32'(busy),      32'd0);
    base_cnt = pulse_cnt;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      #1;
      if (k == 1)  checkOutput("lat_busy_e1", 32'(busy), 32'd1);
      if (k == 16) checkOutput("lat_early_valid", 32'(bcd_valid), 32'd0);
      if (k == 17) begin
        checkOutput("lat_valid_e17", 32'(bcd_valid), 32'd1);
        checkOutput("lat_bcd_e17",   32'(score_bcd), 32'h0001);
        checkOutput("lat_high_e17",  32'(high_bcd),  32'h0001);
      end
      if (k == 18) checkOutput("lat_valid_e18", 32'(bcd_valid), 32'd0);
    end
    checkOutput("lat_pulses", 32'(pulse_cnt - base_cnt), 32'd1);

    // Back to zero, then increments at E0 and E5 (second one mid-SHIFT)
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    settle("clr0");
    base_cnt = pulse_cnt;
    base_q   = pulse_q.size();
    for (int k = 0; k <= 5; k++) begin
      applyStimulus((k == 0) || (k == 5), 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    settle("mid");
    checkOutput("mid_pulses", 32'(pulse_cnt - base_cnt), 32'd2);
    if (pulse_q.size() >= base_q + 2) begin
      checkOutput("mid_first",  32'(pulse_q[base_q]),     32'h0001);
      checkOutput("mid_second", 32'(pulse_q[base_q + 1]), 32'h0002);
    end
    checkOutput("mid_high", 32'(high_bcd), 32'h0002);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      base_cnt = pulse_cnt;
      lost     = vecs[i].lost_lvl;
      cycles   = (vecs[i].n_inc > 0) ? vecs[i].n_inc : 1;
      for (int c = 0; c < cycles; c++) begin
        applyStimulus(c < vecs[i].n_inc, vecs[i].clr && (c == 0));
      end
      applyStimulus(1'b0, 1'b0);
      settle($sformatf("v%0d", i));
      lost = 1'b0;
      checkOutput($sformatf("v%0d_bin", i),  32'(score_bin), 32'(vecs[i].exp_bin));
      checkOutput($sformatf("v%0d_bcd", i),  32'(score_bcd), 32'(vecs[i].exp_bcd));
      checkOutput($sformatf("v%0d_high", i), 32'(high_bcd),  32'(vecs[i].exp_high));
      if (vecs[i].chk_pulse) begin
        checkOutput($sformatf("v%0d_pulses", i), 32'(pulse_cnt - base_cnt),
                    32'(vecs[i].exp_pulse));
      end
    end

    // Reset during SHIFT aborts the conversion with no strobe
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    base_cnt = pulse_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_bin",   32'(score_bin), 32'd0);
    checkOutput("abort_bcd",   32'(score_bcd), 32'd0);
    checkOutput("abort_high",  32'(high_bcd),  32'd0);
    checkOutput("abort_busy",  32'(busy),      32'd0);
    checkOutput("abort_valid", 32'(bcd_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("abort_pulses", 32'(pulse_cnt - base_cnt), 32'd0);

    // Saturation at 9999 with continuous increments
    for (int c = 0; c < 10005; c++) begin
      applyStimulus(1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("sat_bin", 32'(score_bin), 32'd9999);
    settle("sat");
    checkOutput("sat_bcd",  32'(score_bcd), 32'h9999);
    checkOutput("sat_high", 32'(high_bcd),  32'h9999);
    base_cnt = pulse_cnt;
    repeat (40) @(negedge clk);
    checkOutput("sat_quiet", 32'(pulse_cnt - base_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_bcd_encoder.md
Name: score_bcd_encoder

Overview:
- Producer side of the score path to the seven-segment display.
- Keeps the binary game score from pipe-pass pulses and converts it to four packed BCD digits with a sequential double-dabble engine.
- Presents the digits, plus a running high score, to the display driver with a one-cycle update strobe.
- Sits between game logic (pipe/collision FSM) and the display multiplexer.

Parameters:
- SCORE_W, 14, width of binary score register (must hold SCORE_MAX).
- SCORE_MAX, 9999, saturation value for the score.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- score_inc  input  1  one-cycle pulse: bird cleared a pipe.
- score_clr  input  1  one-cycle pulse: new game, score to zero.
- lost  input  1  level: game over; freezes score.
- score_bin  output  SCORE_W  current binary score.
- score_bcd  output  16  {thousands, hundreds, tens, ones} of last converted score.
- high_bcd  output  16  packed BCD maximum of every converted score since reset.
- bcd_valid  output  1  one-cycle pulse when score_bcd is updated.
- busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous active-low.
- Reset values:
  - score_bin, score_bcd and high_bcd are 0.
  - bcd_valid is 0; busy is 0.
  - FSM is IDLE; internal dirty flag is 0.
  - Reset asserted mid-conversion aborts it immediately; no bcd_valid is produced for the aborted conversion.
- Score register, updated at each clk edge, in priority order:
  - score_clr: score_bin <= 0 and dirty <= 1. Applies even if the score is already 0 and regardless of lost.
  - Otherwise score_inc && !lost && score_bin < SCORE_MAX: score_bin <= score_bin + 1 and dirty <= 1.
  - score_inc while lost, or at SCORE_MAX: no change and dirty is not set.
  - score_clr and score_inc in the same cycle: clr wins, result 0.
- FSM states and transitions:
  - IDLE: if dirty, go to LOAD.
  - LOAD: shift register <= score_bin; BCD scratch <= 0; bit counter <= 0; dirty <= 0; go to SHIFT.
  - SHIFT: each cycle, add 3 to every scratch nibble >= 5, then shift {scratch, shift register} left by 1. After SCORE_W SHIFT cycles, go to DONE.
  - DONE: score_bcd <= scratch; bcd_valid <= 1 for exactly one cycle; if scratch > high_bcd (unsigned 16-bit compare, valid for packed BCD), high_bcd <= scratch; go to IDLE.
- busy is combinational from the state register: high in LOAD, SHIFT and DONE.
- Latency: inc sampled at edge E0 gives bcd_valid high in the cycle after edge E0+SCORE_W+3 (17 edges at default).
- Events during busy:
  - score_bin updates immediately and sets dirty.
  - The running conversion completes with the value captured in LOAD.
  - The FSM then returns to IDLE and starts a new conversion.
  - Multiple events during one conversion coalesce into a single reconversion.
- high_bcd is cleared only by rst_n, never by score_clr.
- score_bcd never shows a partially converted value.

Test Plan:
- Reset: hold rst_n=0, toggle inputs -> all outputs 0, busy=0. Release -> no bcd_valid while idle.
- Single inc at edge E0 -> score_bin=1 after E0; busy rises after E1; bcd_valid pulses after E17 with score_bcd=16'h0001 and high_bcd=16'h0001.
- inc at E0, second inc at E5 (mid-SHIFT) -> first bcd_valid shows 16'h0001, second shows 16'h0002; exactly two pulses.
- Continuous inc every cycle for 10005 cycles -> score_bin saturates at 9999; final score_bcd=16'h9999; once the final conversion ends, no further bcd_valid.
- Reach score 37, then score_clr and score_inc in the same cycle -> score_bin=0, score_bcd=16'h0000, high_bcd stays 16'h0037.
- Freeze and abort:
  - lost=1 with 5 inc pulses -> score_bin unchanged, no bcd_valid.
  - rst_n low during SHIFT -> outputs 0 immediately, busy=0, no pulse.
